// File: rtl/axis_rr_fifo_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream sink among N_SRC sources.
// Each grant lasts up to MAX_BURST beats; arbitration costs one idle cycle.
module axis_rr_fifo_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned DATA_W    = 256,
  localparam int unsigned IDW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    axis_clk,
  input  logic                    rst,
  input  logic                    arb_en,
  input  logic [N_SRC-1:0]        s_axis_tvalid,
  output logic [N_SRC-1:0]        s_axis_tready,
  input  logic [N_SRC*DATA_W-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic [IDW-1:0]          m_axis_tid,
  output logic                    busy
);

  localparam int unsigned CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LastBeat = CNTW'(MAX_BURST - 1);
  localparam logic [IDW-1:0]  LastSrc  = IDW'(N_SRC - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  cand;
  logic            cur_vld;

  assign cur_vld = s_axis_tvalid[grant_q];

  // Scan offsets from farthest to nearest so the source just after last_grant wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = IDW'((32'(last_grant_q) + N_SRC - k) % N_SRC);
      if (s_axis_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_en && pick_vld) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        if (!cur_vld) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end else if (m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + CNTW'(1);
          if (beat_cnt_q == LastBeat) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tid    = '0;
    busy          = 1'b0;
    if (state_q == StBurst) begin
      busy                   = 1'b1;
      m_axis_tid             = grant_q;
      m_axis_tvalid          = cur_vld;
      s_axis_tready[grant_q] = m_axis_tready;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (grant_q == IDW'(i)) begin
          m_axis_tdata = s_axis_tdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge axis_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LastSrc;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_fifo_arbiter.sv
// Self-checking bench for axis_rr_fifo_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_axis_rr_fifo_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXB = 8;
  localparam int unsigned DW   = 256;
  localparam int unsigned IDW  = 2;

  logic            axis_clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [IDW-1:0]  m_axis_tid;
  logic            busy;

  always #5 axis_clk = ~axis_clk;

  axis_rr_fifo_arbiter #(.N_SRC(N), .MAX_BURST(MAXB), .DATA_W(DW)) dut (
    .axis_clk      (axis_clk),
    .rst           (rst),
    .arb_en        (arb_en),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Source side: each source owns a sequence number and a count of beats left to offer.
  logic [N-1:0] vld;
  int unsigned  seq[N];
  int unsigned  seq_exp[N];
  int unsigned  remain[N];
  bit           rand_mode = 1'b0;
  bit           tbl_mode  = 1'b0;

  // Reference model: owner of the sink (-1 when none), last owner, beats sent.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_sent  = 0;

  typedef struct {int tid; int beats;} burst_t;
  burst_t bursts[$];
  bit     prev_busy = 1'b0;
  int     cur_tid   = 0;
  int     cur_beats = 0;

  logic [N-1:0]   smp_rdy;
  logic           smp_val;
  logic [IDW-1:0] smp_tid;
  logic           smp_busy;
  logic [DW-1:0]  smp_data;

  typedef struct {
    logic         r;
    logic         en;
    logic         mr;
    logic [N-1:0] v;
    logic [N-1:0] x_rdy;
    logic         x_val;
    int           x_tid;
    logic         x_busy;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [DW-1:0] mk_data(input int src, input int unsigned s);
    logic [31:0] w;
    w = s ^ {8'(src), 24'h5ac3e1};
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit found;
    found = 1'b0;
    if (m_owner < 0) begin
      if (arb_en && (vld != '0)) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && vld[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_sent  = 0;
          end
        end
      end
    end else if (!vld[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_axis_tready) begin
      m_sent++;
      if (m_sent == MAXB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0]  e_rdy;
    logic          e_val;
    int            e_tid;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic [N-1:0]  hs;
    if (!tbl_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) vld[i] = (remain[i] > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]            = vld[i];
      s_axis_tdata[i*DW +: DW]    = mk_data(i, seq[i]);
    end
    if (!rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_sent  = 0;
    end
    @(negedge axis_clk);
    e_rdy = '0; e_val = 1'b0; e_tid = 0; e_data = '0; e_busy = 1'b0;
    if (m_owner >= 0) begin
      e_rdy[m_owner] = m_axis_tready;
      e_val          = vld[m_owner];
      e_tid          = m_owner;
      e_data         = mk_data(m_owner, seq[m_owner]);
      e_busy         = 1'b1;
    end
    smp_rdy = s_axis_tready; smp_val = m_axis_tvalid; smp_tid = m_axis_tid;
    smp_busy = busy; smp_data = m_axis_tdata;
    chk("s_tready", 256'(s_axis_tready), 256'(e_rdy));
    chk("m_tvalid", 256'(m_axis_tvalid), 256'(e_val));
    chk("m_tid", 256'(m_axis_tid), 256'(e_tid));
    chk("busy", 256'(busy), 256'(e_busy));
    chk("m_tdata", m_axis_tdata, e_data);
    if (m_axis_tvalid && m_axis_tready) begin
      chk("sink_order", m_axis_tdata, mk_data(int'(m_axis_tid), seq_exp[m_axis_tid]));
      seq_exp[m_axis_tid]++;
    end
    if (busy) begin
      if (!prev_busy) begin
        cur_tid   = int'(m_axis_tid);
        cur_beats = 0;
      end
      if (m_axis_tvalid && m_axis_tready) cur_beats++;
    end else if (prev_busy) begin
      bursts.push_back('{cur_tid, cur_beats});
    end
    prev_busy = busy;
    hs = vld & s_axis_tready;
    @(posedge axis_clk);
    if (rst) model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (remain[i] > 0) remain[i]--;
        if (!tbl_mode) vld[i] = 1'b0;
      end
    end
  endtask

  task automatic reset_all();
    rst = 1'b0;
    vld = '0;
    for (int i = 0; i < N; i++) remain[i] = 0;
    cycle();
    rst = 1'b1;
    bursts.delete();
  endtask

  initial begin
    rst = 1'b0; arb_en = 1'b1; m_axis_tready = 1'b1; vld = '0;
    s_axis_tvalid = '0; s_axis_tdata = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; seq_exp[i] = 0; remain[i] = 0;
    end

    // rst en mr valid -> tready tvalid tid busy
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1, 2, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1, 2, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1, 2, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0, 2, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b1, 3, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 4'b1011, 4'b1000, 1'b1, 3, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'b0011, 4'b1000, 1'b0, 3, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 4'b0011, 4'b0001, 1'b1, 0, 1'b1};

    tbl_mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].r; arb_en = tbl[i].en; m_axis_tready = tbl[i].mr; vld = tbl[i].v;
      cycle();
      chk("tbl_tready", 256'(smp_rdy), 256'(tbl[i].x_rdy));
      chk("tbl_tvalid", 256'(smp_val), 256'(tbl[i].x_val));
      chk("tbl_tid", 256'(smp_tid), 256'(tbl[i].x_tid));
      chk("tbl_busy", 256'(smp_busy), 256'(tbl[i].x_busy));
    end
    tbl_mode = 1'b0;

    // All sources valid: bursts of MAXB in rotation order.
    reset_all();
    arb_en = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) remain[i] = 1000;
    repeat (48) cycle();
    chk("rr_nbursts", 256'(bursts.size() >= 5), 256'(1));
    for (int k = 0; k < 5 && k < bursts.size(); k++) begin
      chk("rr_tid", 256'(bursts[k].tid), 256'(k % N));
      chk("rr_beats", 256'(bursts[k].beats), 256'(MAXB));
    end

    // Sink stall at beat 4 of src1.
    reset_all();
    remain[1] = 1000;
    repeat (5) cycle();
    m_axis_tready = 1'b0;
    repeat (20) begin
      cycle();
      chk("stall_tid", 256'(smp_tid), 256'(1));
      chk("stall_tready", 256'(smp_rdy), 256'(0));
      chk("stall_busy", 256'(smp_busy), 256'(1));
    end
    m_axis_tready = 1'b1;
    repeat (6) cycle();
    chk("stall_nbursts", 256'(bursts.size() >= 1), 256'(1));
    if (bursts.size() >= 1) begin
      chk("stall_tid_total", 256'(bursts[0].tid), 256'(1));
      chk("stall_beats", 256'(bursts[0].beats), 256'(MAXB));
    end

    // arb_en dropped mid-burst: burst completes, no new grant until re-enabled.
    reset_all();
    for (int i = 0; i < N; i++) remain[i] = 1000;
    repeat (3) cycle();
    arb_en = 1'b0;
    repeat (20) cycle();
    chk("en_nbursts", 256'(bursts.size()), 256'(1));
    if (bursts.size() == 1) begin
      chk("en_tid", 256'(bursts[0].tid), 256'(0));
      chk("en_beats", 256'(bursts[0].beats), 256'(MAXB));
    end
    chk("en_idle", 256'(smp_busy), 256'(0));
    arb_en = 1'b1;
    cycle();
    cycle();
    chk("en_next_tid", 256'(smp_tid), 256'(1));
    chk("en_next_busy", 256'(smp_busy), 256'(1));

    // Reset pulse during src3 burst at beat 5.
    reset_all();
    remain[3] = 1000;
    repeat (6) cycle();
    rst = 1'b0;
    cycle();
    chk("rst_tready", 256'(smp_rdy), 256'(0));
    chk("rst_tvalid", 256'(smp_val), 256'(0));
    chk("rst_busy", 256'(smp_busy), 256'(0));
    chk("rst_tdata", smp_data, 256'(0));
    remain[0] = 1000;
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_first_tid", 256'(smp_tid), 256'(0));
    chk("rst_first_busy", 256'(smp_busy), 256'(1));

    // Randomized traffic, backpressure, enable and reset.
    rand_mode = 1'b1;
    reset_all();
    repeat (3000) begin
      m_axis_tready = ($urandom_range(0, 9) < 8);
      arb_en        = ($urandom_range(0, 19) != 0);
      rst           = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (remain[i] == 0 && $urandom_range(0, 7) == 0) remain[i] = $urandom_range(1, 12);
      end
      cycle();
    end
    rst = 1'b1; arb_en = 1'b1; m_axis_tready = 1'b1;
    repeat (150) cycle();
    for (int i = 0; i < N; i++) begin
      chk("no_loss", 256'(seq_exp[i]), 256'(seq[i]));
      chk("drained", 256'(remain[i]), 256'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
